mem_resp: RTL and testbench

Single-port memory responder on the far side of the 4-way request arbiter's memory port. It accepts one request at a time on addr_m/dout_m/req_m/wr_m and performs the read or write against an internal word array. It completes each request with a one-cycle rdy_m pulse after a programmable number of wait states, then enforces one turnaround cycle so the arbiter can re-arbitrate. It also keeps saturating access counters and flags out-of-range addresses.

---
 rtl/mem_resp.sv | 154 +++++++++++++++
 tb/tb_mem_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp.sv
// Single-port memory responder behind the request arbiter's memory port.
// It serves one read or write at a time against an internal 64-bit word array,
// with programmable wait states, a one-cycle completion pulse and a mandatory
// turnaround cycle. It also keeps saturating access counters and flags
// out-of-range addresses.
module mem_resp #(
    parameter int AW     = 10,  // word-address width; depth = 2**AW words
    parameter int RD_LAT = 2,   // read wait states (0..15)
    parameter int WR_LAT = 1    // write wait states (0..15)
) (
    input  logic        clk,
    input  logic        reset,   // asynchronous, active-low
    input  logic [63:0] addr_m,
    input  logic [63:0] dout_m,
    input  logic        req_m,
    input  logic        wr_m,
    output logic [63:0] din_m,
    output logic        rdy_m,
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_TURN
    } state_t;

    localparam logic [3:0] RD_WAIT = 4'(RD_LAT);
    localparam logic [3:0] WR_WAIT = 4'(WR_LAT);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [63:0]     data_q, data_d;
    logic            wr_q, wr_d;
    logic            oor_q, oor_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;
    logic [63:0]     din_q, din_d;
    logic [31:0]     rd_cnt_q, rd_cnt_d;
    logic [31:0]     wr_cnt_q, wr_cnt_d;
    logic            mem_we;
    logic [3:0]      load_val;

    logic [63:0]     mem [2**AW];

    // Byte-offset bits never select anything; kept visible so lint sees them consumed.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^addr_m[2:0];

    // Next-state, holding-register, response and counter logic.
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        wr_d     = wr_q;
        oor_d    = oor_q;
        rdy_d    = 1'b0;
        err_d    = 1'b0;
        din_d    = din_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        load_val = wr_m ? WR_WAIT : RD_WAIT;

        unique case (state_q)
            S_IDLE: begin
                if (req_m) begin
                    // Capture the whole request; later input changes are ignored.
                    idx_d   = addr_m[AW+2:3];
                    data_d  = dout_m;
                    wr_d    = wr_m;
                    oor_d   = (addr_m[63:AW+3] != '0);
                    cnt_d   = load_val;
                    state_d = (load_val != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // The edge leaving this state completes the access and raises rdy_m.
                rdy_d = 1'b1;
                err_d = oor_q;
                if (wr_q) begin
                    mem_we   = ~oor_q;
                    wr_cnt_d = (wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
                end else begin
                    din_d    = oor_q ? 64'd0 : mem[idx_q];
                    rd_cnt_d = (rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
                end
                state_d = S_TURN;
            end
            S_TURN: begin
                // req_m still shows the old requester here, so it is not sampled.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            data_q   <= 64'd0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            din_q    <= 64'd0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            oor_q    <= oor_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            din_q    <= din_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Word array write port.
    // NOTE: the array has no reset so it maps onto plain RAM; its contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= data_q;
        end
    end

    assign din_m  = din_q;
    assign rdy_m  = rdy_q;
    assign err    = err_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus randomized traffic
// compared against a transaction-level reference model (latency, data, flags,
// counters). A second instance with zero wait states checks pulse spacing.
module tb_mem_resp;

    localparam int AW     = 10;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr_m, dout_m, din_m;
    logic        req_m, wr_m, rdy_m, err;
    logic [31:0] rd_cnt, wr_cnt;

    logic [63:0] addr_z, dout_z, din_z;
    logic        req_z, wr_z, rdy_z, err_z;
    logic [31:0] rd_cnt_z, wr_cnt_z;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] ref_mem [int];
    logic [63:0] ref_din;
    logic [31:0] ref_rd, ref_wr;
    int          written_q [$];

    always #5 clk = ~clk;

    mem_resp #(.AW(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .reset(reset), .addr_m(addr_m), .dout_m(dout_m),
        .req_m(req_m), .wr_m(wr_m), .din_m(din_m), .rdy_m(rdy_m),
        .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    mem_resp #(.AW(AW), .RD_LAT(0), .WR_LAT(0)) dut_z (
        .clk(clk), .reset(reset), .addr_m(addr_z), .dout_m(dout_z),
        .req_m(req_z), .wr_m(wr_z), .din_m(din_z), .rdy_m(rdy_z),
        .err(err_z), .rd_cnt(rd_cnt_z), .wr_cnt(wr_cnt_z)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One complete transaction: issue, update model, check timing/data/flags/counters.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input bit drop_early, input bit wiggle);
        int  lat;
        int  seen;
        bit  oor;
        int  idx;
        lat = w ? WR_LAT : RD_LAT;
        @(negedge clk);
        req_m = 1'b1; wr_m = w; addr_m = a; dout_m = d;
        @(posedge clk);  // acceptance edge E0
        oor = (a[63:AW+3] != '0);
        idx = int'(a[AW+2:3]);
        if (w) begin
            if (!oor) ref_mem[idx] = d;
            ref_wr = sat_inc(ref_wr);
        end else begin
            ref_din = oor ? 64'd0 : ref_mem[idx];
            ref_rd  = sat_inc(ref_rd);
        end
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (drop_early) req_m = 1'b0;
            if (wiggle) begin
                addr_m = {$urandom, $urandom};
                dout_m = {$urandom, $urandom};
                wr_m   = ~w;
            end
            @(posedge clk);
            #1;
            if (rdy_m) begin
                seen = k;
                break;
            end
        end
        check("latency", 64'(seen), 64'(lat + 1));
        check("err", {63'd0, err}, {63'd0, oor});
        check("din", din_m, ref_din);
        check("rd_cnt", {32'd0, rd_cnt}, {32'd0, ref_rd});
        check("wr_cnt", {32'd0, wr_cnt}, {32'd0, ref_wr});
        @(negedge clk);
        req_m = 1'b0; wr_m = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_single", {63'd0, rdy_m}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic        w;
        int          idx;

        reset = 1'b0;
        req_m = 1'b0; wr_m = 1'b0; addr_m = '0; dout_m = '0;
        req_z = 1'b0; wr_z = 1'b0; addr_z = '0; dout_z = '0;
        ref_din = '0; ref_rd = '0; ref_wr = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_rdy", {63'd0, rdy_m}, 64'd0);
        end
        check("idle_err", {63'd0, err}, 64'd0);
        check("idle_din", din_m, 64'd0);
        check("idle_rd_cnt", {32'd0, rd_cnt}, 64'd0);
        check("idle_wr_cnt", {32'd0, wr_cnt}, 64'd0);

        // Write then read with default latencies
        do_req(1'b1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        do_req(1'b0, 64'h40, 64'h0, 1'b0, 1'b0);

        // Out-of-range write must not alias onto word 0
        do_req(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        do_req(1'b1, 64'h1_0000_0000, 64'h1234, 1'b0, 1'b0);
        do_req(1'b0, 64'h1_0000_0000, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        written_q.push_back(0);
        written_q.push_back(8);

        // Request dropped and inputs changed during WAIT
        do_req(1'b0, 64'h47, 64'h0, 1'b1, 1'b1);

        // Reset during WAIT of a write to 0x80 aborts it
        do_req(1'b1, 64'h80, 64'hAAAA_5555_AAAA_5555, 1'b0, 1'b0);
        written_q.push_back(16);
        @(negedge clk);
        req_m = 1'b1; wr_m = 1'b1; addr_m = 64'h80; dout_m = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_m = 1'b0; wr_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_rdy", {63'd0, rdy_m}, 64'd0);
        end
        @(negedge clk) reset = 1'b1;
        ref_din = '0; ref_rd = '0; ref_wr = '0;
        @(posedge clk);
        #1;
        check("abort_rdy_after", {63'd0, rdy_m}, 64'd0);
        check("abort_wr_cnt", {32'd0, wr_cnt}, 64'd0);
        check("abort_din", din_m, 64'd0);
        do_req(1'b0, 64'h80, 64'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 1) == 1);
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                a = {$urandom, $urandom};
                a[40] = 1'b1;
            end else if (w) begin
                idx = int'($urandom_range(0, 2**AW - 1));
                a = 64'(idx) << 3;
                a[2:0] = 3'($urandom);
                written_q.push_back(idx);
            end else begin
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                a = 64'(idx) << 3;
                a[2:0] = 3'($urandom);
            end
            do_req(w, a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Counter saturation
        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.wr_cnt_q;
        ref_wr = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        check("sat_preload", {32'd0, wr_cnt}, {32'd0, ref_wr});
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 64'h100 + 64'(i * 8), {$urandom, $urandom}, 1'b0, 1'b0);
        end
        check("sat_final", {32'd0, wr_cnt}, 64'hFFFF_FFFF);

        // Zero wait states: requests held continuously, pulse every third cycle
        @(negedge clk);
        req_z = 1'b1; wr_z = 1'b0; addr_z = 64'h18;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("zlat_rdy_%0d", k), {63'd0, rdy_z}, {63'd0, (k % 3) == 1});
        end
        @(negedge clk) req_z = 1'b0;
        check("zlat_rd_cnt", {32'd0, rd_cnt_z}, 64'd5);
        check("zlat_wr_cnt", {32'd0, wr_cnt_z}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
